// File: rtl/lsr_serializer_pkg.sv
// Shared types and helpers for the load/shift serializer.
package lsr_serializer_pkg;

    // Controller states.
    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_SHIFTING = 1'b1
    } state_t;

    // Values of MSB_FIRST: which end of the register is emitted.
    localparam bit EMIT_MSB = 1'b1;
    localparam bit EMIT_LSB = 1'b0;

    // Width of a counter that must hold every value from 0 to steps.
    function automatic int count_width(input int steps);
        return $clog2(steps + 1);
    endfunction

endpackage

// File: rtl/lsr_serializer_if.sv
// Word-in / chunk-out handshake bundle between the fetch logic and the serializer.
interface lsr_serializer_if
    import lsr_serializer_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int SHIFT_AMOUNT = 1
);
    localparam int STEPS   = WIDTH / SHIFT_AMOUNT;
    localparam int COUNT_W = count_width(STEPS);

    logic [WIDTH-1:0]        in_DATA;
    logic                    in_VALID;
    logic                    out_READY;
    logic                    in_SHIFT;
    logic [SHIFT_AMOUNT-1:0] in_SERIAL;
    logic [SHIFT_AMOUNT-1:0] out_BITS;
    logic                    out_VALID;
    logic                    out_DONE;
    logic [WIDTH-1:0]        out_DATA;
    logic [COUNT_W-1:0]      out_COUNT;

    // Word source / step requester side.
    modport master (
        output in_DATA, in_VALID, in_SHIFT, in_SERIAL,
        input  out_READY, out_BITS, out_VALID, out_DONE, out_DATA, out_COUNT
    );

    // Serializer side.
    modport slave (
        input  in_DATA, in_VALID, in_SHIFT, in_SERIAL,
        output out_READY, out_BITS, out_VALID, out_DONE, out_DATA, out_COUNT
    );

endinterface

// File: rtl/lsr_step_counter.sv
// Steps-remaining counter: loads STEPS, decrements per step, flags the last step.
module lsr_step_counter
    import lsr_serializer_pkg::*;
#(
    parameter int STEPS   = 8,
    parameter int COUNT_W = count_width(STEPS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               dec,
    output logic [COUNT_W-1:0] count,
    output logic               last
);

    // Load takes priority so a final step and a new word can coincide.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= COUNT_W'(STEPS);
        end else if (dec && (count != '0)) begin
            count <= count - COUNT_W'(1);
        end
    end

    // The step taken while count is 1 finishes the word.
    always_comb begin
        last = (count == COUNT_W'(1));
    end

endmodule

// File: rtl/lsr_serializer.sv
// Load/shift serializer: takes a WIDTH-bit word and emits it SHIFT_AMOUNT
// bits per step from the chosen end, with zero-bubble back-to-back loads.
//
//   state       | meaning
//   ------------+-------------------------------------------------
//   ST_IDLE     | no word held; ready for a load, steps ignored
//   ST_SHIFTING | word in flight; out_BITS is an unsent chunk
module lsr_serializer
    import lsr_serializer_pkg::*;
#(
    parameter int               WIDTH        = 8,
    parameter int               SHIFT_AMOUNT = 1,
    parameter bit               MSB_FIRST    = 1'b1,
    parameter logic [WIDTH-1:0] RST_VALUE    = '0
) (
    input logic            clk,
    input logic            rst,
    lsr_serializer_if.slave bus
);

    localparam int STEPS   = WIDTH / SHIFT_AMOUNT;
    localparam int COUNT_W = count_width(STEPS);

    if ((SHIFT_AMOUNT < 1) || ((WIDTH % SHIFT_AMOUNT) != 0)) begin : g_bad_shift
        $error("lsr_serializer: SHIFT_AMOUNT (%0d) must divide WIDTH (%0d)", SHIFT_AMOUNT, WIDTH);
    end

    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   shreg_q;
    logic [WIDTH-1:0]   shifted;
    logic [COUNT_W-1:0] count;
    logic               last;
    logic               ready;
    logic               step;
    logic               accept;
    logic               done_q;

    lsr_step_counter #(
        .STEPS   (STEPS),
        .COUNT_W (COUNT_W)
    ) u_step_counter (
        .clk   (clk),
        .rst   (rst),
        .load  (accept),
        .dec   (step),
        .count (count),
        .last  (last)
    );

    // Next state, load acceptance and step qualification.
    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        step    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ready = 1'b1;
                if (bus.in_VALID) begin
                    state_d = ST_SHIFTING;
                end
            end
            ST_SHIFTING: begin
                step  = bus.in_SHIFT;
                // A new word may only enter on the step that empties the old one.
                ready = last & bus.in_SHIFT;
                if (bus.in_SHIFT && last && !bus.in_VALID) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign accept = bus.in_VALID & ready;

    // Shift toward the emit side; the vacated end takes the cascade fill bits.
    if (MSB_FIRST == EMIT_MSB) begin : g_msb
        always_comb begin
            shifted = (shreg_q << SHIFT_AMOUNT) | WIDTH'(bus.in_SERIAL);
        end
        assign bus.out_BITS = shreg_q[WIDTH-1 -: SHIFT_AMOUNT];
    end else begin : g_lsb
        always_comb begin
            shifted = (shreg_q >> SHIFT_AMOUNT) | (WIDTH'(bus.in_SERIAL) << (WIDTH - SHIFT_AMOUNT));
        end
        assign bus.out_BITS = shreg_q[SHIFT_AMOUNT-1:0];
    end

    // Shift register: a load beats a step when both happen on the last step.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q <= RST_VALUE;
        end else if (accept) begin
            shreg_q <= bus.in_DATA;
        end else if (step) begin
            shreg_q <= shifted;
        end
    end

    // State register and the completion pulse following the final step.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= step & last;
        end
    end

    assign bus.out_READY = ready;
    assign bus.out_VALID = (state_q == ST_SHIFTING);
    assign bus.out_DONE  = done_q;
    assign bus.out_DATA  = shreg_q;
    assign bus.out_COUNT = count;

endmodule

// File: tb/tb_lsr_serializer.sv
// Scoreboard bench for two serializer configurations:
//   dut0: WIDTH=8, SHIFT_AMOUNT=1, MSB-first, reset value 0x00
//   dut1: WIDTH=8, SHIFT_AMOUNT=2, LSB-first, reset value 0x5C
module tb_lsr_serializer;

    typedef struct {
        bit valid;
        bit ready;
        bit done;
        int count;
        bit chk_bits;
        int bits;
        int data;
    } rec_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    lsr_serializer_if #(.WIDTH(8), .SHIFT_AMOUNT(1)) bus0 ();
    lsr_serializer_if #(.WIDTH(8), .SHIFT_AMOUNT(2)) bus1 ();

    lsr_serializer #(
        .WIDTH(8), .SHIFT_AMOUNT(1), .MSB_FIRST(1'b1), .RST_VALUE(8'h00)
    ) dut0 (
        .clk(clk), .rst(rst), .bus(bus0.slave)
    );

    lsr_serializer #(
        .WIDTH(8), .SHIFT_AMOUNT(2), .MSB_FIRST(1'b0), .RST_VALUE(8'h5C)
    ) dut1 (
        .clk(clk), .rst(rst), .bus(bus1.slave)
    );

    // stimulus per dut
    bit v_in  [2];
    int d_in  [2];
    bit sh_in [2];
    int ser_in[2];

    // reference model per dut
    int rem    [2];
    bit done_p [2];
    int mdata  [2];
    int chunks [2][$];

    rec_t sq[2][$];

    int n_checks = 0;
    int n_fail   = 0;

    function automatic int sa_of(input int i);
        return (i == 0) ? 1 : 2;
    endfunction

    function automatic bit msb_of(input int i);
        return (i == 0);
    endfunction

    function automatic int rv_of(input int i);
        return (i == 0) ? 8'h00 : 8'h5C;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            rem[i]    = 0;
            done_p[i] = 1'b0;
            mdata[i]  = rv_of(i);
            chunks[i].delete();
        end
    endtask

    task automatic idle_inputs();
        for (int i = 0; i < 2; i++) begin
            v_in[i]   = 1'b0;
            d_in[i]   = 0;
            sh_in[i]  = 1'b0;
            ser_in[i] = 0;
        end
    endtask

    task automatic apply_inputs();
        bus0.in_VALID  = v_in[0];
        bus0.in_DATA   = 8'(d_in[0]);
        bus0.in_SHIFT  = sh_in[0];
        bus0.in_SERIAL = 1'(ser_in[0]);
        bus1.in_VALID  = v_in[1];
        bus1.in_DATA   = 8'(d_in[1]);
        bus1.in_SHIFT  = sh_in[1];
        bus1.in_SERIAL = 2'(ser_in[1]);
    endtask

    // One clock cycle: drive inputs, record what the outputs must show now,
    // then advance the model across the coming edge.
    task automatic tick();
        rec_t r;
        int   p;
        int   steps;
        bit   rdy;
        bit   acc;
        bit   stp;
        apply_inputs();
        for (int i = 0; i < 2; i++) begin
            p     = 1 << sa_of(i);
            steps = 8 / sa_of(i);
            rdy   = (rem[i] == 0) || ((rem[i] == 1) && sh_in[i]);
            r.valid    = (rem[i] > 0);
            r.ready    = rdy;
            r.done     = done_p[i];
            r.count    = rem[i];
            r.chk_bits = (rem[i] > 0) && (chunks[i].size() > 0);
            r.bits     = r.chk_bits ? chunks[i][0] : 0;
            r.data     = mdata[i];
            sq[i].push_back(r);
            if (rst) begin
                rem[i]    = 0;
                done_p[i] = 1'b0;
                mdata[i]  = rv_of(i);
                chunks[i].delete();
            end else begin
                acc       = v_in[i] && rdy;
                stp       = (rem[i] > 0) && sh_in[i];
                done_p[i] = stp && (rem[i] == 1);
                if (stp) begin
                    void'(chunks[i].pop_front());
                    rem[i] = rem[i] - 1;
                    if (msb_of(i)) mdata[i] = (mdata[i] * p + ser_in[i]) % 256;
                    else           mdata[i] = mdata[i] / p + ser_in[i] * (256 / p);
                end
                if (acc) begin
                    chunks[i].delete();
                    for (int k = 0; k < steps; k++) begin
                        if (msb_of(i)) chunks[i].push_back((d_in[i] >> (8 - sa_of(i) * (k + 1))) % p);
                        else           chunks[i].push_back((d_in[i] >> (sa_of(i) * k)) % p);
                    end
                    mdata[i] = d_in[i];
                    rem[i]   = steps;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input int i, input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL dut%0d %s at %0t: actual %0d required %0d", i, name, $time, act, exp);
        end
    endtask

    task automatic check_rec(input int i, input rec_t r, input bit av, input bit ar,
                             input bit ad, input int ac, input int ab, input int adt);
        chk(i, "out_VALID", int'(av), int'(r.valid));
        chk(i, "out_READY", int'(ar), int'(r.ready));
        chk(i, "out_DONE",  int'(ad), int'(r.done));
        chk(i, "out_COUNT", ac, r.count);
        chk(i, "out_DATA",  adt, r.data);
        if (r.chk_bits) chk(i, "out_BITS", ab, r.bits);
    endtask

    // Monitor: compare each presented output set against the queued expectation.
    always @(negedge clk) begin
        if (sq[0].size() > 0) begin
            check_rec(0, sq[0].pop_front(), bus0.out_VALID, bus0.out_READY, bus0.out_DONE,
                      int'(bus0.out_COUNT), int'(bus0.out_BITS), int'(bus0.out_DATA));
        end
        if (sq[1].size() > 0) begin
            check_rec(1, sq[1].pop_front(), bus1.out_VALID, bus1.out_READY, bus1.out_DONE,
                      int'(bus1.out_COUNT), int'(bus1.out_BITS), int'(bus1.out_DATA));
        end
    end

    initial begin
        idle_inputs();
        apply_inputs();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        tick();

        // MSB-first single-bit word 0xA5
        v_in[0] = 1'b1; d_in[0] = 8'hA5; tick();
        v_in[0] = 1'b0; sh_in[0] = 1'b1; repeat (8) tick();
        idle_inputs(); repeat (2) tick();

        // LSB-first two-bit word 0xB4
        v_in[1] = 1'b1; d_in[1] = 8'hB4; tick();
        v_in[1] = 1'b0; sh_in[1] = 1'b1; repeat (4) tick();
        idle_inputs(); repeat (2) tick();

        // back-to-back: 0x3C offered on the final step of 0xA5
        v_in[0] = 1'b1; d_in[0] = 8'hA5; tick();
        v_in[0] = 1'b0; sh_in[0] = 1'b1; repeat (7) tick();
        v_in[0] = 1'b1; d_in[0] = 8'h3C; tick();
        v_in[0] = 1'b0; repeat (8) tick();
        idle_inputs(); repeat (2) tick();

        // reset mid-word, then a normal word
        v_in[0] = 1'b1; d_in[0] = 8'hFF; v_in[1] = 1'b1; d_in[1] = 8'hFF; tick();
        idle_inputs(); sh_in[0] = 1'b1; sh_in[1] = 1'b1; repeat (3) tick();
        idle_inputs(); rst = 1'b1; tick();
        rst = 1'b0; tick();
        v_in[0] = 1'b1; d_in[0] = 8'h5A; v_in[1] = 1'b1; d_in[1] = 8'h5A; tick();
        idle_inputs(); sh_in[0] = 1'b1; sh_in[1] = 1'b1; repeat (8) tick();
        idle_inputs(); repeat (2) tick();

        // step request while idle is ignored
        sh_in[0] = 1'b1; sh_in[1] = 1'b1; ser_in[0] = 1; ser_in[1] = 3; tick();
        idle_inputs(); tick();

        // offer held while count=5: refused until the last step, then taken
        v_in[0] = 1'b1; d_in[0] = 8'h96; tick();
        v_in[0] = 1'b0; sh_in[0] = 1'b1; repeat (3) tick();
        v_in[0] = 1'b1; d_in[0] = 8'h11; sh_in[0] = 1'b0; repeat (3) tick();
        sh_in[0] = 1'b1; repeat (5) tick();
        v_in[0] = 1'b0; repeat (8) tick();
        idle_inputs(); repeat (2) tick();

        // fill from in_SERIAL
        v_in[0] = 1'b1; d_in[0] = 8'h00; v_in[1] = 1'b1; d_in[1] = 8'h00; tick();
        idle_inputs(); sh_in[0] = 1'b1; sh_in[1] = 1'b1; ser_in[0] = 1; ser_in[1] = 3;
        repeat (8) tick();
        idle_inputs(); repeat (2) tick();

        // randomized traffic
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            for (int i = 0; i < 2; i++) begin
                v_in[i]   = ($urandom_range(0, 9) < 4);
                d_in[i]   = int'($urandom_range(0, 255));
                sh_in[i]  = ($urandom_range(0, 9) < 7);
                ser_in[i] = int'($urandom_range(0, (1 << sa_of(i)) - 1));
            end
            tick();
        end
        rst = 1'b0;
        idle_inputs(); repeat (3) tick();

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
